// File: rtl/jk_bank_driver.sv
// Write-side controller for a bank of jkff cells: it takes a target vector, derives J/K from the fed-back Q, then checks and retries.
// Optional JK_TOGGLE_DRIVE_EN: bits that must change are driven J=K=1 (toggle) instead of using set/reset encoding.
module jk_bank_driver #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  input  logic [WIDTH-1:0] tgt_data,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int unsigned CNT_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] RETRY_LIMIT = CNT_W'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] err_mask_q, err_mask_d;
  logic [WIDTH-1:0] chg_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tgt_q      <= '0;
      retry_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_mask_q <= '0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      retry_q    <= retry_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_mask_q <= err_mask_d;
    end
  end

  // Next-state and response logic; retry_cnt only increments below the limit, so it saturates there.
  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    retry_d    = retry_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_mask_d = err_mask_q;
    case (state_q)
      ST_IDLE: begin
        if (tgt_valid) begin
          tgt_d      = tgt_data;
          retry_d    = '0;
          err_mask_d = '0;
          state_d    = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (q_in == tgt_q) begin
          done_d  = 1'b1;
          state_d = ST_RESP;
        end else if (retry_q < RETRY_LIMIT) begin
          retry_d = retry_q + CNT_W'(1);
          state_d = ST_DRIVE;
        end else begin
          err_d      = 1'b1;
          err_mask_d = q_in ^ tgt_q;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Excitation is live only in DRIVE and is killed by reset so a partial drive never reaches the bank.
  always_comb begin
    chg_c = tgt_q ^ q_in;
    j_out = '0;
    k_out = '0;
    if (!rst && (state_q == ST_DRIVE)) begin
`ifdef JK_TOGGLE_DRIVE_EN
      j_out = chg_c;
      k_out = chg_c;
`else
      j_out = chg_c & tgt_q;
      k_out = chg_c & q_in;
`endif
    end
  end

  assign tgt_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_mask  = err_mask_q;

endmodule
